// File: rtl/rvl_ctrl_mbox.sv
// Debug/user mailbox register bank: a shared word array whose top NUM_CH words
// are request/response mailboxes with overrun flags and completion pulses.
module rvl_ctrl_mbox #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 4
) (
   input  logic                  usr_clk,
   input  logic                  usr_rst_n,
   input  logic                  ctl_ce,
   input  logic                  ctl_we,
   input  logic [ADDR_WIDTH-1:0] ctl_addr,
   input  logic [DATA_WIDTH-1:0] ctl_wdata,
   output logic [DATA_WIDTH-1:0] ctl_rdata,
   output logic [NUM_CH-1:0]     ctl_done,
   output logic [NUM_CH-1:0]     ctl_ovf,
   input  logic [NUM_CH-1:0]     ctl_ovf_clr,
   input  logic                  usr_ce,
   input  logic                  usr_we,
   input  logic [ADDR_WIDTH-1:0] usr_addr,
   input  logic [DATA_WIDTH-1:0] usr_wdata,
   output logic [DATA_WIDTH-1:0] usr_rdata,
   output logic [NUM_CH-1:0]     usr_req,
   output logic                  usr_wr_coll
);

   // state   | meaning
   // ST_IDLE | mailbox empty, waiting for a ctl-side request
   // ST_REQ  | ctl request pending, waiting for the usr-side response write
   typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} ch_state_t;

   localparam int DEPTH   = 1 << ADDR_WIDTH;
   localparam int MB_BASE = DEPTH - NUM_CH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   ch_state_t             r_state [NUM_CH];
   logic [DATA_WIDTH-1:0] r_ctl_rdata;
   logic [DATA_WIDTH-1:0] r_usr_rdata;
   logic [NUM_CH-1:0]     r_done;
   logic [NUM_CH-1:0]     r_ovf;
   logic [NUM_CH-1:0]     r_req;
   logic                  r_coll;

   logic                  w_ctl_wr;
   logic                  w_usr_wr;
   logic                  w_coll;
   logic                  w_usr_wr_ok;
   logic [NUM_CH-1:0]     w_ctl_mb;
   logic [NUM_CH-1:0]     w_usr_mb;

   assign w_ctl_wr    = ctl_ce & ctl_we;
   assign w_usr_wr    = usr_ce & usr_we;
   assign w_coll      = w_ctl_wr & w_usr_wr & (ctl_addr == usr_addr);
   assign w_usr_wr_ok = w_usr_wr & ~w_coll;

   always_comb begin
      w_ctl_mb = '0;
      w_usr_mb = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_ctl_mb[c] = w_ctl_wr    & (ctl_addr == ADDR_WIDTH'(MB_BASE + c));
         w_usr_mb[c] = w_usr_wr_ok & (usr_addr == ADDR_WIDTH'(MB_BASE + c));
      end
   end

   // Storage is deliberately not reset; a colliding usr write is already masked.
   always_ff @(posedge usr_clk) begin
      if (w_ctl_wr)    r_mem[ctl_addr] <= ctl_wdata;
      if (w_usr_wr_ok) r_mem[usr_addr] <= usr_wdata;
   end

   always_ff @(posedge usr_clk or negedge usr_rst_n) begin
      if (!usr_rst_n) begin
         r_ctl_rdata <= '0;
         r_usr_rdata <= '0;
      end else begin
         if (ctl_ce && !ctl_we) r_ctl_rdata <= r_mem[ctl_addr];
         if (usr_ce && !usr_we) r_usr_rdata <= r_mem[usr_addr];
      end
   end

   always_ff @(posedge usr_clk or negedge usr_rst_n) begin
      if (!usr_rst_n) begin
         for (int c = 0; c < NUM_CH; c++) r_state[c] <= ST_IDLE;
         r_done <= '0;
         r_ovf  <= '0;
         r_req  <= '0;
         r_coll <= 1'b0;
      end else begin
         r_coll <= w_coll;
         for (int c = 0; c < NUM_CH; c++) begin
            r_done[c] <= 1'b0;
            r_req[c]  <= (r_state[c] == ST_REQ);
            r_ovf[c]  <= r_ovf[c] & ~ctl_ovf_clr[c];
            case (r_state[c])
               ST_IDLE: begin
                  if (w_ctl_mb[c]) r_state[c] <= ST_REQ;
               end
               ST_REQ: begin
                  if (w_ctl_mb[c]) begin
                     r_ovf[c] <= 1'b1;
                  end else if (w_usr_mb[c]) begin
                     r_state[c] <= ST_IDLE;
                     r_done[c]  <= 1'b1;
                  end
               end
               default: r_state[c] <= ST_IDLE;
            endcase
         end
      end
   end

   assign ctl_rdata   = r_ctl_rdata;
   assign usr_rdata   = r_usr_rdata;
   assign ctl_done    = r_done;
   assign ctl_ovf     = r_ovf;
   assign usr_req     = r_req;
   assign usr_wr_coll = r_coll;

endmodule
